// File: rtl/wb_select_stage_pkg.sv
// Shared definitions for the write-back select stage: source select codes
// and load-extraction mode encodings.
package wb_select_stage_pkg;

    typedef enum logic [3:0] {
        WB_SEL_ALU   = 4'd0,
        WB_SEL_LDSZ  = 4'd1,
        WB_SEL_MEM   = 4'd2,
        WB_SEL_RD    = 4'd3,
        WB_SEL_SE1   = 4'd4,
        WB_SEL_CONST = 4'd5,
        WB_SEL_RB    = 4'd6,
        WB_SEL_HI    = 4'd7,
        WB_SEL_LO    = 4'd8
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_WORD = 2'b00,
        LD_HALF = 2'b01,
        LD_BYTE = 2'b10,
        LD_RSVD = 2'b11
    } ld_mode_e;

endpackage

// File: rtl/wb_select_stage_load_extract.sv
// Combinational load extraction: picks a byte or halfword out of a memory
// word and sign/zero-extends it. Word and reserved modes pass unchanged.
module load_extract
    import wb_select_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        off,
    input  logic [1:0]        mode,
    input  logic              sgn,
    output logic [DATA_W-1:0] result
);

    logic        [15:0] half_u;
    logic signed [15:0] half_s;
    logic        [7:0]  byte_u;
    logic signed [7:0]  byte_s;

    // Shift the addressed lane down to bit 0, then extend to full width.
    always_comb begin
        half_u = 16'(word >> {off[1], 4'b0000});
        byte_u = 8'(word >> {off, 3'b000});
        half_s = half_u;
        byte_s = byte_u;
        case (mode)
            LD_HALF: result = sgn ? DATA_W'(half_s) : DATA_W'(half_u);
            LD_BYTE: result = sgn ? DATA_W'(byte_s) : DATA_W'(byte_u);
            default: result = word;
        endcase
    end

endmodule

// File: rtl/wb_select_stage.sv
// Registered write-back selector: picks a datapath source or constant,
// extracts loads, and holds one result for the register-file write port.
module wb_select_stage
    import wb_select_stage_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_SRC   = 9,
    parameter int SEL_W     = 4,
    parameter int CONST_IDX = WB_SEL_CONST,
    parameter int CONST_VAL = 227,
    parameter int MEM_IDX   = WB_SEL_MEM,
    parameter int ADDR_W    = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*DATA_W-1:0] src_bus,
    input  logic [SEL_W-1:0]          sel,
    input  logic [1:0]                ld_mode,
    input  logic                      ld_signed,
    input  logic [1:0]                ld_off,
    input  logic [ADDR_W-1:0]         dst_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_W-1:0]         wb_data,
    output logic [ADDR_W-1:0]         wb_dst,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic                      sel_err
);

    // state    | meaning
    // ST_IDLE  | no write-back pending, wb_valid low
    // ST_FULL  | wb_data/wb_dst hold a pending write-back
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    state_e            state;
    logic              accept;
    logic              sel_hit;
    logic              sel_bad;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] next_data;

    assign wb_valid = (state == ST_FULL);
    assign in_ready = !wb_valid || wb_ready;
    assign accept   = in_valid && in_ready;

    // Bus slice for the selected source; an unmatched code yields zero.
    always_comb begin
        sel_hit  = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_hit  = 1'b1;
                sel_data = src_bus[i*DATA_W +: DATA_W];
            end
        end
    end

    load_extract #(.DATA_W(DATA_W)) u_load_extract (
        .word   (sel_data),
        .off    (ld_off),
        .mode   (ld_mode),
        .sgn    (ld_signed),
        .result (ext_data)
    );

    // Constant code wins over any bus slice; extraction only on the memory code.
    always_comb begin
        sel_bad = 1'b0;
        if (sel == SEL_W'(CONST_IDX)) begin
            next_data = DATA_W'(CONST_VAL);
        end else if (sel == SEL_W'(MEM_IDX) && sel_hit) begin
            next_data = ext_data;
        end else begin
            next_data = sel_data;
            sel_bad   = !sel_hit;
        end
    end

    // One-entry output register; writes to register 0 are consumed but dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            wb_data <= '0;
            wb_dst  <= '0;
            sel_err <= 1'b0;
        end else begin
            if (accept && sel_bad) begin
                sel_err <= 1'b1;
            end
            if (accept && (dst_in != '0)) begin
                state   <= ST_FULL;
                wb_data <= next_data;
                wb_dst  <= dst_in;
            end else if (wb_ready) begin
                state   <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_wb_select_stage.sv
// Scoreboard bench for wb_select_stage: the driver pushes expected write-backs
// on accept, a monitor pops and compares whenever one is consumed.
module tb_wb_select_stage;
    import wb_select_stage_pkg::*;

    localparam int DATA_W  = 32;
    localparam int NUM_SRC = 9;
    localparam int SEL_W   = 4;
    localparam int ADDR_W  = 5;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] dst;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_SRC*DATA_W-1:0] src_bus;
    logic [SEL_W-1:0]          sel;
    logic [1:0]                ld_mode;
    logic                      ld_signed;
    logic [1:0]                ld_off;
    logic [ADDR_W-1:0]         dst_in;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         wb_data;
    logic [ADDR_W-1:0]         wb_dst;
    logic                      wb_valid;
    logic                      wb_ready;
    logic                      sel_err;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    wb_select_stage dut (
        .clk       (clk),
        .reset     (reset),
        .src_bus   (src_bus),
        .sel       (sel),
        .ld_mode   (ld_mode),
        .ld_signed (ld_signed),
        .ld_off    (ld_off),
        .dst_in    (dst_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wb_data   (wb_data),
        .wb_dst    (wb_dst),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one request (caller is just after a rising edge); push the
    // expected result on the edge that accepts it.
    task automatic send(input logic [3:0] s, input logic [1:0] md, input logic sg,
                        input logic [1:0] of, input logic [4:0] d,
                        input logic [31:0] exp_data);
        bit done = 0;
        sel = s; ld_mode = md; ld_signed = sg; ld_off = of; dst_in = d;
        in_valid = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                if (d != 5'd0) sb.push_back('{data: exp_data, dst: d});
                #1;
                done = 1;
            end
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: in_ready never rose for dst %0d", d);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every consumed write-back must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && wb_valid && wb_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_wb", {27'd0, wb_dst}, 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wb_data", wb_data, e.data);
                    chk("wb_dst", {27'd0, wb_dst}, {27'd0, e.dst});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        reset = 1'b1; src_bus = '0; sel = '0; ld_mode = 2'b00; ld_signed = 1'b0;
        ld_off = 2'b00; dst_in = '0; in_valid = 1'b0; wb_ready = 1'b1;
        src_bus[0*32 +: 32] = 32'h1234_5678;
        src_bus[1*32 +: 32] = 32'hCAFE_F00D;
        src_bus[2*32 +: 32] = 32'h80FF_7F01;
        src_bus[5*32 +: 32] = 32'hFFFF_FFFF;
        src_bus[8*32 +: 32] = 32'h0BAD_C0DE;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_dst", {27'd0, wb_dst}, 32'd0);
        chk("rst_sel_err", {31'd0, sel_err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        send(4'd0, LD_WORD, 1'b0, 2'd0, 5'd8, 32'h1234_5678);
        @(negedge clk);
        chk("latency_wb_valid", {31'd0, wb_valid}, 32'd1);
        @(posedge clk); #1;

        // Back-to-back requests with wb_ready high.
        send(4'd5, LD_WORD, 1'b0, 2'd0, 5'd9,  32'h0000_00E3);
        send(4'd2, LD_BYTE, 1'b1, 2'd3, 5'd10, 32'hFFFF_FF80);
        send(4'd2, LD_HALF, 1'b0, 2'd2, 5'd11, 32'h0000_80FF);
        send(4'd2, LD_HALF, 1'b1, 2'd0, 5'd12, 32'h0000_7F01);
        send(4'd2, LD_BYTE, 1'b0, 2'd1, 5'd13, 32'h0000_007F);
        send(4'd2, LD_HALF, 1'b1, 2'd3, 5'd14, 32'hFFFF_80FF);
        send(4'd2, LD_RSVD, 1'b1, 2'd1, 5'd15, 32'h80FF_7F01);
        send(4'd1, LD_BYTE, 1'b1, 2'd3, 5'd16, 32'hCAFE_F00D);
        send(4'd8, LD_WORD, 1'b0, 2'd0, 5'd17, 32'h0BAD_C0DE);
        idle(2);
        chk("sel_err_clean", {31'd0, sel_err}, 32'd0);

        // Stall: the entry must hold while wb_ready is low, then hand over cleanly.
        wb_ready = 1'b0;
        send(4'd0, LD_WORD, 1'b0, 2'd0, 5'd20, 32'h1234_5678);
        fork
            send(4'd1, LD_WORD, 1'b0, 2'd0, 5'd21, 32'hCAFE_F00D);
            begin
                @(negedge clk);
                held = wb_data;
                chk("stall_held_first", held, 32'h1234_5678);
                repeat (3) begin
                    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("stall_wb_valid", {31'd0, wb_valid}, 32'd1);
                    chk("stall_wb_data", wb_data, held);
                    chk("stall_wb_dst", {27'd0, wb_dst}, 32'd20);
                    @(negedge clk);
                end
                @(posedge clk); #1;
                wb_ready = 1'b1;
            end
        join
        idle(3);
        chk("stall_drained", sb.size(), 32'd0);

        // Invalid select: zero data, sticky error.
        send(4'd12, LD_WORD, 1'b0, 2'd0, 5'd22, 32'h0000_0000);
        @(negedge clk);
        chk("sel_err_set", {31'd0, sel_err}, 32'd1);
        @(posedge clk); #1;
        send(4'd0, LD_WORD, 1'b0, 2'd0, 5'd23, 32'h1234_5678);
        idle(2);
        chk("sel_err_sticky", {31'd0, sel_err}, 32'd1);

        // Register 0 writes are consumed without raising wb_valid.
        send(4'd0, LD_WORD, 1'b0, 2'd0, 5'd0, 32'h0);
        @(negedge clk);
        chk("dst0_no_valid", {31'd0, wb_valid}, 32'd0);
        chk("dst0_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Reset while FULL discards the entry; requests during reset are ignored.
        wb_ready = 1'b0;
        send(4'd8, LD_WORD, 1'b0, 2'd0, 5'd24, 32'h0BAD_C0DE);
        reset = 1'b1;
        sel = 4'd0; dst_in = 5'd25; in_valid = 1'b1;
        @(negedge clk);
        chk("pre_rst_full", {31'd0, wb_valid}, 32'd1);
        @(posedge clk); #1;
        sb.delete();
        @(negedge clk);
        chk("rst_full_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_clears_err", {31'd0, sel_err}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b0;
        wb_ready = 1'b1;
        @(negedge clk);
        chk("rst_req_ignored", {31'd0, wb_valid}, 32'd0);
        @(posedge clk); #1;

        send(4'd5, LD_BYTE, 1'b1, 2'd0, 5'd26, 32'h0000_00E3);
        idle(3);
        chk("sb_empty_end", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_select_stage.md
# wb_select_stage

Parametrised, registered write-back selector for the multi-cycle MIPS datapath: picks one of `NUM_SRC` data sources (or a built-in constant), optionally byte/halfword-extracts and sign/zero-extends memory data, and presents the result with its destination register index to the register file through a valid/ready handshake. It sits between the datapath source registers (ALUOut, MDR, HI/LO, shifter, …) and the register-file write port. It replaces the fixed 9-way combinational write-back mux with a one-entry output register, load extraction and sticky select-error reporting.

## Interface
- `DATA_W`, 32, data width (multiple of 8, ≥16)
- `NUM_SRC`, 9, number of packed source inputs
- `SEL_W`, 4, select width; `2**SEL_W > NUM_SRC` required
- `CONST_IDX`, 5, select code that returns `CONST_VAL` instead of a bus slice
- `CONST_VAL`, 227, constant driven when `sel == CONST_IDX`
- `MEM_IDX`, 2, select code to which load extraction applies
- `ADDR_W`, 5, destination register index width
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `src_bus`  in  NUM_SRC*DATA_W  source i at bits [i*DATA_W +: DATA_W]
- `sel`  in  SEL_W  source select
- `ld_mode`  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
- `ld_signed`  in  1  1 = sign-extend, 0 = zero-extend
- `ld_off`  in  2  byte offset within word (half uses `ld_off[1]`)
- `dst_in`  in  ADDR_W  destination register index
- `in_valid`  in  1  request valid
- `in_ready`  out  1  stage can accept
- `wb_data`  out  DATA_W  registered write-back data
- `wb_dst`  out  ADDR_W  registered destination index
- `wb_valid`  out  1  write-back pending
- `wb_ready`  in  1  register file consumes this cycle
- `sel_err`  out  1  sticky: an accepted request had an invalid select

## Operation
- Accept when `in_valid && in_ready`; `in_ready = !wb_valid || wb_ready` (combinational, single-entry pass-through).
- Data selection on accept: `sel == CONST_IDX` → `CONST_VAL` (zero-extended to DATA_W, takes priority over any bus slice); `sel < NUM_SRC` → slice `sel`; otherwise → 0 and `sel_err` set.
- Load extraction only when `sel == MEM_IDX`: half → bits [16*ld_off[1] +: 16]; byte → bits [8*ld_off +: 8]; extended per `ld_signed`. Word/reserved modes pass unchanged. `ld_*` ignored for other selects.
- Writes to register 0 (`dst_in == 0`) are accepted and dropped: `wb_valid` not set, `in_ready` unaffected.
- Output state: IDLE (`wb_valid=0`) → FULL on accept; FULL → IDLE on `wb_ready` without new accept; FULL → FULL with new data on simultaneous `wb_ready` and accept.
- Held outputs (`wb_data`, `wb_dst`) are stable while `wb_valid && !wb_ready`.
- `sel_err` clears only on `reset`.

## Timing
- Latency: accept in cycle N → `wb_valid`/`wb_data` visible cycle N+1.
- Throughput: one request per cycle when `wb_ready` held high.
- Reset (sync): `wb_valid=0`, `wb_data=0`, `wb_dst=0`, `sel_err=0`; an entry pending at reset is discarded; requests presented during reset are ignored.
- No combinational path from `src_bus`/`sel` to outputs; only `wb_ready` → `in_ready` is combinational.

## Structure
- Shared package: select codes (`WB_SEL_ALU=0`, `WB_SEL_LDSZ=1`, `WB_SEL_MEM=2`, `WB_SEL_RD=3`, `WB_SEL_SE1=4`, `WB_SEL_CONST=5`, `WB_SEL_RB=6`, `WB_SEL_HI=7`, `WB_SEL_LO=8`), `ld_mode` encodings.
- One sub-module: `load_extract` (purely combinational; word, offset, mode, sign → DATA_W result).

## Test plan
- Reset, then `sel=0`, `src0=0x1234_5678`, `dst_in=8`, `in_valid=1`, `wb_ready=1` → next cycle `wb_valid=1`, `wb_data=0x1234_5678`, `wb_dst=8`.
- `sel=5`, bus slice 5 = 0xFFFF_FFFF → `wb_data=0x0000_00E3`.
- `sel=2`, slice 2 = 0x80FF_7F01, byte, `ld_off=3`, signed → `0xFFFF_FF80`; half, `ld_off=2`, unsigned → `0x0000_80FF`.
- `wb_ready=0` for 3 cycles after accept → `in_ready=0`, outputs frozen; `wb_ready=1` with new request → `wb_data` updates next cycle, no request lost or duplicated.
- `sel=12` accepted → `wb_data=0`, `sel_err=1`, stays 1 across later valid requests until `reset`.
- `dst_in=0` accepted → `wb_valid` stays 0; `reset` asserted while FULL → `wb_valid=0` next cycle.
